rr_stream_mux: RTL and testbench

//  N-channel, WIDTH-bit streaming multiplexer with valid/ready handshake and one registered output stage.
//  Two source-select modes:
//   - fixed: the sel port picks the source.
//   - round-robin: an arbiter picks among requesting sources.

---
 rtl/rr_stream_mux_pkg.sv | 32 +++
 rtl/rr_stream_mux_arbiter.sv | 57 +++++
 rtl/rr_stream_mux.sv | 167 ++++++++++++++++
 tb/tb_rr_stream_mux.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the rr_stream_mux fabric multiplexer: source-select
// mode encodings, lock FSM state type and index-width helpers.
package rr_stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    // Ceiling log2 as a constant function, shared with the other fabric muxes.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Channel index width; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter. The request vector is rotated so that the
// channel after the pointer lands in bit 0, then the lowest set bit wins.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int PTRW = ptr_width(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [PTRW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [PTRW-1:0] gnt_idx_o
);

    localparam logic [PTRW:0] N_W = (PTRW + 1)'(N);

    logic [PTRW:0]  start_s;
    logic [PTRW:0]  idx_s;
    logic [2*N-1:0] req_dbl_s;
    logic [N-1:0]   rot_s;
    logic           found_s;

    // Rotate the doubled request vector by ptr+1 and priority-encode the result.
    always_comb begin
        start_s = {1'b0, ptr_i} + {{PTRW{1'b0}}, 1'b1};
        if (start_s >= N_W) begin
            start_s = start_s - N_W;
        end else begin
            start_s = start_s;
        end
        req_dbl_s = {req_i, req_i} >> start_s;
        rot_s     = req_dbl_s[N-1:0];
        found_s   = 1'b0;
        idx_s     = '0;
        gnt_idx_o = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && rot_s[k]) begin
                found_s = 1'b1;
                idx_s   = start_s + (PTRW + 1)'(k);
                if (idx_s >= N_W) begin
                    idx_s = idx_s - N_W;
                end else begin
                    idx_s = idx_s;
                end
                gnt_idx_o = idx_s[PTRW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            gnt_o = {{(N-1){1'b0}}, 1'b1} << gnt_idx_o;
        end else begin
            gnt_o = '0;
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// Sources are chosen by sel (fixed mode) or by a round-robin arbiter; once a
// multi-beat packet starts, its owner is locked until the last beat is taken.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic [N-1:0]       grant,
    output logic               locked
);

    localparam int PTRW = ptr_width(N);

    lock_state_e     state_q, state_d;
    logic [PTRW-1:0] owner_q, owner_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;

    logic [N-1:0]    arb_gnt_s, fix_gnt_s, grant_s, in_ready_s;
    logic [PTRW-1:0] arb_idx_s, fix_idx_s, grant_idx_s;
    logic            can_load_s, accept_s, sel_last_s;
    logic [WIDTH-1:0] sel_data_s;

    rr_arbiter #(
        .N    (N),
        .PTRW (PTRW)
    ) u_arb (
        .req_i     (in_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt_s),
        .gnt_idx_o (arb_idx_s)
    );

    // Fixed-mode winner: sel must name an existing, valid channel; otherwise no grant.
    always_comb begin
        fix_gnt_s = '0;
        for (int i = 0; i < N; i++) begin
            fix_gnt_s[i] = in_valid[i] && (sel == SELW'(i));
        end
        fix_idx_s = PTRW'(sel);
    end

    // Current owner: frozen while locked, otherwise the mode's combinational winner.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = owner_q;
        if (state_q == ST_LOCKED) begin
            grant_s     = {{(N-1){1'b0}}, 1'b1} << owner_q;
            grant_idx_s = owner_q;
        end else if (mode == MODE_RR) begin
            grant_s     = arb_gnt_s;
            grant_idx_s = arb_idx_s;
        end else begin
            grant_s     = fix_gnt_s;
            grant_idx_s = fix_idx_s;
        end
    end

    // Ready fan-out, acceptance and the AND-OR data/last select over the one-hot grant.
    always_comb begin
        can_load_s = !out_valid_q || out_ready;
        if (rst) begin
            in_ready_s = '0;
        end else begin
            in_ready_s = grant_s & {N{can_load_s}};
        end
        accept_s   = |(in_valid & in_ready_s);
        sel_data_s = '0;
        sel_last_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
            sel_last_s = sel_last_s | (in_last[i] & grant_s[i]);
        end
    end

    // Lock FSM, owner capture, RR pointer advance and output register next state.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !sel_last_s) begin
                    state_d = ST_LOCKED;
                    owner_d = grant_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && sel_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The pointer moves only when a packet completes, in either mode.
        if (accept_s && sel_last_s) begin
            ptr_d = grant_idx_s;
        end else begin
            ptr_d = ptr_q;
        end
        if (can_load_s) begin
            out_valid_d = accept_s;
            if (accept_s) begin
                out_data_d = sel_data_s;
                out_last_d = sel_last_s;
            end else begin
                out_data_d = out_data_q;
                out_last_d = out_last_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset drops any packet in flight and restarts RR at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= PTRW'(N - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign grant     = grant_s;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: per-channel beat queues feed a driver,
// expected output beats are queued at stimulus time and popped by a monitor.
module tb_rr_stream_mux;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [1:0]     sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_last, in_ready, grant;
    logic [W-1:0]   out_data;
    logic           out_valid, out_last, out_ready, locked;

    // Second instance with three channels for the out-of-range sel case.
    logic [1:0]  d3_sel;
    logic [23:0] d3_in_data = 24'h33_22_11;
    logic [2:0]  d3_in_valid = 3'b111;
    logic [2:0]  d3_in_last = 3'b111;
    logic [2:0]  d3_in_ready, d3_grant;
    logic [7:0]  d3_out_data;
    logic        d3_out_valid, d3_out_last, d3_locked;
    logic        d3_mode = 1'b0;
    logic        d3_out_ready = 1'b1;

    beat_t ch_q[N][$];
    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    rr_stream_mux #(.N(N), .WIDTH(W), .SELW(2)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .grant(grant), .locked(locked)
    );

    rr_stream_mux #(.N(3), .WIDTH(8), .SELW(2)) u_dut3 (
        .clk(clk), .rst(rst), .mode(d3_mode), .sel(d3_sel),
        .in_data(d3_in_data), .in_valid(d3_in_valid), .in_last(d3_in_last), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_valid(d3_out_valid), .out_last(d3_out_last), .out_ready(d3_out_ready),
        .grant(d3_grant), .locked(d3_locked)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    task automatic push_beat(input int ch, input logic [W-1:0] d, input logic l, input bit to_exp);
        beat_t b;
        b.data = d;
        b.last = l;
        ch_q[ch].push_back(b);
        if (to_exp) exp_q.push_back(b);
    endtask

    function automatic bit chans_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (ch_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Wait (bounded) until all stimulus and expected beats are consumed.
    task automatic wait_drain(input string name, input logic [N-1:0] forbid, input int budget);
        int  cyc = 0;
        bit  done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            if (forbid != '0) check({name, "_forbidden_ready"}, 64'(in_ready & forbid), 64'd0);
            #1;
            cyc++;
            done = (exp_q.size() == 0) && chans_empty();
        end
        if (!done) fail({name, "_timeout"}, "drain did not complete");
    endtask

    // Driver: retire accepted beats and present each channel's next beat.
    initial begin
        logic [N-1:0] acc;
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        forever begin
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && ch_q[i].size() > 0) void'(ch_q[i].pop_front());
                if (ch_q[i].size() > 0) begin
                    in_valid[i]          = 1'b1;
                    in_data[i*W +: W]    = ch_q[i][0].data;
                    in_last[i]           = ch_q[i][0].last;
                end else begin
                    in_valid[i]          = 1'b0;
                    in_data[i*W +: W]    = '0;
                    in_last[i]           = 1'b0;
                end
            end
        end
    end

    // Monitor: every beat the sink takes must match the head of the expected queue.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail("sb_extra", $sformatf("unexpected beat %0h", out_data));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 64'(out_data), 64'(e.data));
                    check("sb_last", 64'(out_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int lock_seen;
        rst       = 1'b1;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        d3_sel    = 2'd3;

        // 1/3. Reset with every channel valid, then RR fairness over two rounds.
        for (int i = 0; i < N; i++) push_beat(i, 32'h10 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < N; i++) push_beat(i, 32'h20 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < N; i++) exp_q.push_back('{data: 32'h10 + 32'(i), last: 1'b1});
        for (int i = 0; i < N; i++) exp_q.push_back('{data: 32'h20 + 32'(i), last: 1'b1});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rr_grant_%0d", k), 64'(grant), 64'(4'b0001 << (k % 4)));
        end
        wait_drain("rr", 4'b0000, 50);

        // 2. Fixed mode, ch2 four-beat packet; other channels never ready.
        mode = 1'b0;
        sel  = 2'd2;
        for (int k = 0; k < 4; k++) push_beat(2, 32'hA0 + 32'(k), (k == 3), 1'b1);
        wait_drain("fixed", 4'b1011, 50);

        // 4. Lock: ch1 packet, sel/mode changed and ch0 raised mid-packet.
        sel = 2'd1;
        for (int k = 0; k < 3; k++) push_beat(1, 32'hB0 + 32'(k), (k == 2), 1'b1);
        cyc = 0;
        while (ch_q[1].size() != 2 && cyc < 50) begin
            @(negedge clk);
            #1 cyc++;
        end
        if (ch_q[1].size() != 2) fail("lock_start_timeout", "first ch1 beat not taken");
        mode = 1'b1;
        sel  = 2'd0;
        push_beat(0, 32'hD0, 1'b1, 1'b1);
        lock_seen = 0;
        cyc = 0;
        while (!((exp_q.size() == 0) && chans_empty()) && cyc < 50) begin
            @(negedge clk);
            if (locked === 1'b1) begin
                lock_seen++;
                check("lock_grant", 64'(grant), 64'(4'b0010));
                check("lock_ch0_ready", 64'(in_ready[0]), 64'd0);
            end
            #1 cyc++;
        end
        if (cyc >= 50) fail("lock_timeout", "lock packet did not drain");
        check("lock_seen", 64'(lock_seen != 0), 64'd1);

        // 5. Backpressure mid-packet on a ch2 five-beat packet.
        mode = 1'b0;
        sel  = 2'd2;
        for (int k = 0; k < 5; k++) push_beat(2, 32'hF0 + 32'(k), (k == 4), 1'b1);
        cyc = 0;
        while (exp_q.size() != 3 && cyc < 50) begin
            @(negedge clk);
            #1 cyc++;
        end
        if (exp_q.size() != 3) fail("stall_start_timeout", "first two beats not delivered");
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'h0000_00F2);
            check("stall_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain("stall", 4'b0000, 50);

        // 6a. Reset while locked drops the packet.
        sel = 2'd3;
        push_beat(3, 32'hE0, 1'b0, 1'b1);
        push_beat(3, 32'hE1, 1'b0, 1'b1);
        push_beat(3, 32'hE2, 1'b1, 1'b0);
        cyc = 0;
        while (ch_q[3].size() != 2 && cyc < 50) begin
            @(negedge clk);
            #1 cyc++;
        end
        if (ch_q[3].size() != 2) fail("rstlock_timeout", "first ch3 beat not taken");
        check("rstlock_locked_before", 64'(locked), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        ch_q[3].delete();
        @(negedge clk);
        check("rstlock_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstlock_locked_after", 64'(locked), 64'd0);
        check("rstlock_valid_after", 64'(out_valid), 64'd0);
        check("rstlock_grant_after", 64'(grant), 64'd0);

        // 6b. Three-channel instance: sel=3 names no channel.
        check("n3_sel3_grant", 64'(d3_grant), 64'd0);
        check("n3_sel3_ready", 64'(d3_in_ready), 64'd0);
        check("n3_sel3_valid", 64'(d3_out_valid), 64'd0);
        @(posedge clk);
        #1 d3_sel = 2'd2;
        @(negedge clk);
        check("n3_sel2_grant", 64'(d3_grant), 64'(3'b100));
        check("n3_sel2_ready", 64'(d3_in_ready), 64'(3'b100));

        wait_drain("final", 4'b0000, 20);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
